// File: rtl/instruction_memory_pkg.sv
// Processor-wide instruction store constants and the instruction word type.
// Shared by the fetch stage and the instruction memory.
package instruction_memory_pkg;

   localparam int INSTR_W     = 16;
   localparam int IMEM_ADDR_W = 5;
   localparam int IMEM_DEPTH  = 32;

   typedef logic [INSTR_W-1:0] instr_t;

endpackage : instruction_memory_pkg

// File: rtl/instruction_memory.sv
// Synchronous instruction store: one write port, one registered read port.
// Reads are read-first when they collide with a write to the same word.
module instruction_memory
   import instruction_memory_pkg::*;
#(
   parameter int DATA_W = INSTR_W,
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DEPTH  = IMEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_enable,
   input  logic              write_enable,
   output logic [DATA_W-1:0] read_data,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_addr,
   input  logic [ADDR_W-1:0] write_addr
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] read_data_r;

   // Storage array: cleared on reset so no X can ever be fetched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (write_enable) begin
         mem_r[write_addr] <= write_data;
      end
   end

   // Registered read; the non-blocking update gives read-first on collision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_data_r <= '0;
      end else if (read_enable) begin
         read_data_r <= mem_r[read_addr];
      end
   end

   assign read_data = read_data_r;

endmodule : instruction_memory

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed vector tables,
// an asynchronous reset sequence and randomized traffic against an array model.
module tb_instruction_memory;

   localparam int DW = 16;
   localparam int AW = 5;
   localparam int DP = 32;

   logic          clk;
   logic          rst;
   logic          read_enable;
   logic          write_enable;
   logic [DW-1:0] read_data;
   logic [DW-1:0] write_data;
   logic [AW-1:0] read_addr;
   logic [AW-1:0] write_addr;

   int n_checks;
   int n_fails;

   // reference model: plain array plus the last value fetched
   logic [DW-1:0] model_mem [DP];
   logic [DW-1:0] model_rd;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          re;
      logic [AW-1:0] raddr;
      logic [DW-1:0] exp;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   instruction_memory dut (
      .clk          (clk),
      .rst          (rst),
      .read_enable  (read_enable),
      .write_enable (write_enable),
      .read_data    (read_data),
      .write_data   (write_data),
      .read_addr    (read_addr),
      .write_addr   (write_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: read_data=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DP; i++) model_mem[i] = '0;
      model_rd = '0;
   endtask

   // drive one cycle, advance the model by the same rules, return its prediction
   task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra, output logic [DW-1:0] pred);
      write_enable = we;
      write_addr   = wa;
      write_data   = wd;
      read_enable  = re;
      read_addr    = ra;
      @(posedge clk);
      #1;
      if (re) model_rd = model_mem[ra];
      if (we) model_mem[wa] = wd;
      pred = model_rd;
   endtask

   task automatic run_vec(input int idx);
      logic [DW-1:0] pred;
      cycle(vecs[idx].we, vecs[idx].waddr, vecs[idx].wdata, vecs[idx].re, vecs[idx].raddr, pred);
      check($sformatf("vec%0d", idx), read_data, vecs[idx].exp);
      check($sformatf("vec%0d_model", idx), read_data, pred);
   endtask

   initial begin
      logic [DW-1:0] pred;
      n_checks = 0;
      n_fails  = 0;

      // load, readback, hold
      vecs[0]  = '{1'b1, 5'd0,  16'hF0F0, 1'b0, 5'd0,  16'h0000};
      vecs[1]  = '{1'b1, 5'd1,  16'hFFF0, 1'b0, 5'd0,  16'h0000};
      vecs[2]  = '{1'b1, 5'd2,  16'hFFFF, 1'b0, 5'd0,  16'h0000};
      vecs[3]  = '{1'b1, 5'd3,  16'h0000, 1'b0, 5'd0,  16'h0000};
      vecs[4]  = '{1'b1, 5'd4,  16'hF000, 1'b0, 5'd0,  16'h0000};
      vecs[5]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd0,  16'hF0F0};
      vecs[6]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd1,  16'hFFF0};
      vecs[7]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd2,  16'hFFFF};
      vecs[8]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd4,  16'hFFFF};
      vecs[9]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd3,  16'h0000};
      vecs[10] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd4,  16'hF000};
      // after the mid-run reset: collision, boundaries, independent ports
      vecs[11] = '{1'b1, 5'd3,  16'hABCD, 1'b1, 5'd3,  16'h0000};
      vecs[12] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd3,  16'hABCD};
      vecs[13] = '{1'b1, 5'd31, 16'h1234, 1'b0, 5'd0,  16'hABCD};
      vecs[14] = '{1'b1, 5'd0,  16'h5678, 1'b0, 5'd31, 16'hABCD};
      vecs[15] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd31, 16'h1234};
      vecs[16] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd0,  16'h5678};
      vecs[17] = '{1'b1, 5'd5,  16'h1111, 1'b1, 5'd31, 16'h1234};
      vecs[18] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd5,  16'h1111};

      // reset held with a write pending: the write must be ignored
      rst          = 1'b0;
      write_enable = 1'b1;
      write_addr   = 5'd0;
      write_data   = 16'h0070;
      read_enable  = 1'b1;
      read_addr    = 5'd0;
      model_clear();
      @(posedge clk);
      write_addr = 5'd1;
      @(posedge clk);
      #1;
      check("reset_hold", read_data, 16'h0000);
      rst = 1'b1;
      cycle(1'b0, 5'd0, 16'h0000, 1'b1, 5'd0, pred);
      check("post_reset_addr0", read_data, 16'h0000);
      cycle(1'b0, 5'd0, 16'h0000, 1'b1, 5'd1, pred);
      check("post_reset_addr1", read_data, 16'h0000);

      for (int i = 0; i <= 10; i++) run_vec(i);

      // async reset between edges with a write in flight
      write_enable = 1'b1;
      write_addr   = 5'd2;
      write_data   = 16'hBEEF;
      read_enable  = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_immediate", read_data, 16'h0000);
      model_clear();
      @(posedge clk);
      #1;
      check("async_reset_hold", read_data, 16'h0000);
      rst = 1'b1;
      for (int a = 0; a < 5; a++) begin
         cycle(1'b0, 5'd0, 16'h0000, 1'b1, a[AW-1:0], pred);
         check($sformatf("cleared_addr%0d", a), read_data, 16'h0000);
      end

      for (int i = 11; i < NV; i++) run_vec(i);

      // randomized traffic; same-address collisions are forced often
      for (int n = 0; n < 400; n++) begin
         logic          we;
         logic          re;
         logic [AW-1:0] wa;
         logic [AW-1:0] ra;
         logic [DW-1:0] wd;
         we = 1'($urandom_range(0, 1));
         re = 1'($urandom_range(0, 3) != 0);
         ra = AW'($urandom_range(0, DP - 1));
         wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, DP - 1));
         wd = DW'($urandom);
         cycle(we, wa, wd, re, ra, pred);
         check("random", read_data, pred);
      end

      // full sweep against the model
      for (int a = 0; a < DP; a++) begin
         cycle(1'b0, 5'd0, 16'h0000, 1'b1, a[AW-1:0], pred);
         check($sformatf("sweep_addr%0d", a), read_data, pred);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_instruction_memory

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
Single-port-write, single-port-read synchronous instruction store for the pipelined processor's fetch stage. It holds DEPTH words of DATA_W bits. Words are loaded through the write port (bootstrap/test loading) and fetched through the read port. Both ports are clocked; read data is registered.

Parameters:
DATA_W, 16, instruction word width in bits
ADDR_W, 5, address width in bits
DEPTH, 32, number of words (must equal 2**ADDR_W)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
read_enable  input  1  when 1, the word at read_addr is latched into read_data on the next rising edge
write_enable  input  1  when 1, write_data is stored at write_addr on the rising edge
read_data  output  DATA_W  registered read result
write_data  input  DATA_W  word to store
read_addr  input  ADDR_W  read word address
write_addr  input  ADDR_W  write word address

Behaviour:
- Reset (rst=0, asynchronous assert; synchronous-safe deassert): every storage word cleared to 0, read_data cleared to 0. While rst=0, writes and reads are ignored.
- Write: at rising clk with rst=1 and write_enable=1, mem[write_addr] <= write_data. With write_enable=0, memory is unchanged.
- Read: at rising clk with rst=1 and read_enable=1, read_data <= mem[read_addr]. Latency is 1 cycle: the address presented before edge N appears on read_data after edge N.
- read_enable=0: read_data holds its last value. It is not cleared.
- Simultaneous read and write to the same address in one cycle: read-first. read_data receives the old contents; the new value is visible on the next enabled read.
- Simultaneous read and write to different addresses are independent, with no interaction.
- All addresses 0..DEPTH-1 are valid. There is no out-of-range case, and addresses do not wrap beyond ADDR_W bits.
- Reset asserted mid-operation: an in-flight write is discarded and contents and read_data go to 0 immediately, without waiting for clk.
- No X may appear on read_data after the first reset.

Decomposition:
- Shared package (processor-wide): INSTR_W=16, IMEM_ADDR_W=5, IMEM_DEPTH=32, and an instruction word typedef of INSTR_W bits.
- Implement as a single module: storage array, write process, and registered read process. No sub-module.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with write_enable=1 and write_data=16'h0070 -> read_data=0. After release, reading addresses 0 and 1 returns 0, confirming the write was ignored during reset.
2. Sequential load and readback: write addr0=F0F0, addr1=FFF0, addr2=FFFF, addr3=0000, addr4=F000. Then set read_enable=1 and step read_addr 0..4, one per cycle -> read_data equals F0F0, FFF0, FFFF, 0000, F000, each appearing one cycle after its address.
3. Hold: after reading addr2 (FFFF), drop read_enable and change read_addr to 4 -> read_data stays FFFF.
4. Read-first collision: mem[3]=0000. Same cycle, write addr3=ABCD and read addr3 -> read_data=0000. Next cycle, read addr3 -> ABCD.
5. Boundary addresses: write addr31=1234 and addr0=5678, then read both -> 1234 and 5678, with no aliasing between the two.
6. Async reset mid-run: after test 2, pulse rst low between clock edges -> read_data becomes 0 immediately. Reading addresses 0..4 afterwards returns 0.
